alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 31 +++
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_issue.sv | 117 +++++++++++
 tb/tb_alu_issue.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// =============================================================================
// alu_issue_pkg : state encoding, opcode constants and widths for alu_issue
// Revision      : 1.0
// =============================================================================
package alu_issue_pkg;

   localparam int DATA_W    = 8;
   localparam int REG_COUNT = 8;
   localparam int ADDR_W    = $clog2(REG_COUNT);
   localparam int OPC_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h1;

   function automatic logic is_cmp_op(input logic [OPC_W-1:0] op);
      return op[3:2] == 2'b11;
   endfunction

   function automatic logic is_ov_op(input logic [OPC_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// =============================================================================
// alu_issue_if : decoded-instruction handshake into alu_issue
// Revision     : 1.0
// =============================================================================
interface alu_issue_if
   import alu_issue_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) ();
   logic             IN_Valid;
   logic             IN_Ready;
   logic [OPC_W-1:0] IN_OPCode;
   logic [AW-1:0]    IN_Dst;
   logic [AW-1:0]    IN_SrcA;
   logic [AW-1:0]    IN_SrcB;
   logic             IN_UseImm;
   logic [DW-1:0]    IN_Imm;

   modport master (
      output IN_Valid, IN_OPCode, IN_Dst, IN_SrcA, IN_SrcB, IN_UseImm, IN_Imm,
      input  IN_Ready
   );

   modport slave (
      input  IN_Valid, IN_OPCode, IN_Dst, IN_SrcA, IN_SrcB, IN_UseImm, IN_Imm,
      output IN_Ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// =============================================================================
// alu_regfile : working registers, two operand read ports, one debug read port
// Revision    : 1.0
// =============================================================================
module alu_regfile #(
   parameter int REG_COUNT = 8,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = $clog2(REG_COUNT)
) (
   input  logic              CLK,
   input  logic              CPU_Reset,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] rd_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);
   logic [DATA_W-1:0] regs [REG_COUNT];

   always_ff @(posedge CLK or posedge CPU_Reset) begin
      if (CPU_Reset) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not bypassed.
   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];
   assign rd_data = regs[rd_addr];
endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// =============================================================================
// alu_issue : serialised IDLE/EXEC/WB issue stage driving an external ALU
// Revision  : 1.0
// =============================================================================
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int   REG_COUNT = 8,
   parameter int   DATA_W    = 8,
   localparam int  AW        = $clog2(REG_COUNT)
) (
   input  logic              CLK,
   input  logic              CPU_Reset,
   alu_issue_if.slave        in_if,
   output logic [OPC_W-1:0]  ALU_OPCode,
   output logic [DATA_W-1:0] ALU_A,
   output logic [DATA_W-1:0] ALU_B,
   output logic              COMPARATORREG_EN,
   output logic              OV_EN,
   input  logic [DATA_W-1:0] ALU_Resoult,
   input  logic              ALU_ComparatorResoult,
   input  logic              ALU_OV,
   output logic              CMP_Flag,
   output logic              DONE,
   input  logic [AW-1:0]     RD_Addr,
   output logic [DATA_W-1:0] RD_Data
);
   state_t            state;
   logic              ready_q;
   logic [OPC_W-1:0]  op_q;
   logic [AW-1:0]     dst_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic              wb_we;
   logic              ov_unused;

   // The overflow flag is consumed by downstream status logic, not by issue.
   assign ov_unused = ALU_OV;

   assign wb_we = (state == ST_WB) && !is_cmp_op(op_q);

   alu_regfile #(
      .REG_COUNT (REG_COUNT),
      .DATA_W    (DATA_W)
   ) u_regfile (
      .CLK       (CLK),
      .CPU_Reset (CPU_Reset),
      .ra_addr   (in_if.IN_SrcA),
      .rb_addr   (in_if.IN_SrcB),
      .rd_addr   (RD_Addr),
      .ra_data   (ra_data),
      .rb_data   (rb_data),
      .rd_data   (RD_Data),
      .we        (wb_we),
      .wr_addr   (dst_q),
      .wr_data   (ALU_Resoult)
   );

   always_ff @(posedge CLK or posedge CPU_Reset) begin
      if (CPU_Reset) begin
         state            <= ST_IDLE;
         ready_q          <= 1'b1;
         op_q             <= '0;
         dst_q            <= '0;
         a_q              <= '0;
         b_q              <= '0;
         OV_EN            <= 1'b0;
         COMPARATORREG_EN <= 1'b0;
         DONE             <= 1'b0;
         CMP_Flag         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_if.IN_Valid && ready_q) begin
                  op_q             <= in_if.IN_OPCode;
                  dst_q            <= in_if.IN_Dst;
                  a_q              <= ra_data;
                  b_q              <= in_if.IN_UseImm ? in_if.IN_Imm : rb_data;
                  OV_EN            <= is_ov_op(in_if.IN_OPCode);
                  COMPARATORREG_EN <= is_cmp_op(in_if.IN_OPCode);
                  ready_q          <= 1'b0;
                  state            <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               OV_EN            <= 1'b0;
               COMPARATORREG_EN <= 1'b0;
               DONE             <= 1'b1;
               state            <= ST_WB;
            end
            ST_WB: begin
               // The ALU comparator register was loaded on the EXEC->WB edge.
               if (is_cmp_op(op_q)) CMP_Flag <= ALU_ComparatorResoult;
               DONE    <= 1'b0;
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               OV_EN            <= 1'b0;
               COMPARATORREG_EN <= 1'b0;
               DONE             <= 1'b0;
               ready_q          <= 1'b1;
               state            <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_if.IN_Ready = ready_q;
   assign ALU_OPCode     = op_q;
   assign ALU_A          = a_q;
   assign ALU_B          = b_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// =============================================================================
// tb_alu_issue : scoreboard bench for alu_issue with a small behavioural ALU
// Revision     : 1.0
// =============================================================================
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic       CLK = 1'b0;
   logic       CPU_Reset = 1'b1;
   logic [3:0] ALU_OPCode;
   logic [7:0] ALU_A, ALU_B, ALU_Resoult, RD_Data;
   logic       COMPARATORREG_EN, OV_EN, CMP_Flag, DONE;
   logic       ALU_ComparatorResoult, ALU_OV;
   logic [2:0] RD_Addr = 3'd0;

   always #5 CLK = ~CLK;

   alu_issue_if bus ();

   alu_issue dut (
      .CLK                   (CLK),
      .CPU_Reset             (CPU_Reset),
      .in_if                 (bus),
      .ALU_OPCode            (ALU_OPCode),
      .ALU_A                 (ALU_A),
      .ALU_B                 (ALU_B),
      .COMPARATORREG_EN      (COMPARATORREG_EN),
      .OV_EN                 (OV_EN),
      .ALU_Resoult           (ALU_Resoult),
      .ALU_ComparatorResoult (ALU_ComparatorResoult),
      .ALU_OV                (ALU_OV),
      .CMP_Flag              (CMP_Flag),
      .DONE                  (DONE),
      .RD_Addr               (RD_Addr),
      .RD_Data               (RD_Data)
   );

   // Behavioural ALU: combinational result, registered carry/borrow and compare.
   logic [8:0] alu_wide;
   logic       alu_cmp;
   always_comb begin
      alu_wide = '0;
      case (ALU_OPCode)
         4'h0:    alu_wide = {1'b0, ALU_A} + {1'b0, ALU_B};
         4'h1:    alu_wide = {1'b0, ALU_A} - {1'b0, ALU_B};
         4'h2:    alu_wide = {1'b0, ALU_A & ALU_B};
         4'h3:    alu_wide = {1'b0, ALU_A | ALU_B};
         4'h4:    alu_wide = {1'b0, ALU_A ^ ALU_B};
         default: alu_wide = '0;
      endcase
      alu_cmp = (ALU_OPCode == 4'hC) ? (ALU_A == ALU_B) :
                (ALU_OPCode == 4'hD) ? (ALU_A <  ALU_B) : 1'b0;
   end
   assign ALU_Resoult = alu_wide[7:0];

   always @(posedge CLK or posedge CPU_Reset) begin
      if (CPU_Reset) begin
         ALU_OV                <= 1'b0;
         ALU_ComparatorResoult <= 1'b0;
      end else begin
         if (OV_EN)            ALU_OV                <= alu_wide[8];
         if (COMPARATORREG_EN) ALU_ComparatorResoult <= alu_cmp;
      end
   end

   typedef struct packed {
      logic [3:0] op;
      logic [2:0] dst, sa, sb;
      logic       ui;
      logic [7:0] imm, a, b, res;
      logic       ov_en, cmp_en, chk_ov, ov, cmpf;
   } vec_t;

   typedef struct packed {
      vec_t        v;
      logic [63:0] hs;
   } exp_t;

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] val;
      logic       chk_cmp;
      logic       cmpf;
   } rd_t;

   exp_t exp_q[$];
   rd_t  rd_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [2:0] dst, sa, sb,
                               input logic ui, input logic [7:0] imm, a, b, res,
                               input logic ov_en, cmp_en, chk_ov, ov, cmpf);
      vec_t v;
      v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.ui = ui; v.imm = imm;
      v.a = a; v.b = b; v.res = res;
      v.ov_en = ov_en; v.cmp_en = cmp_en; v.chk_ov = chk_ov; v.ov = ov; v.cmpf = cmpf;
      return v;
   endfunction

   function automatic rd_t mkrd(input logic [2:0] addr, input logic [7:0] val,
                                input logic chk_cmp, input logic cmpf);
      rd_t r;
      r.addr = addr; r.val = val; r.chk_cmp = chk_cmp; r.cmpf = cmpf;
      return r;
   endfunction

   // Monitor: services debug reads and retires scoreboard entries on DONE.
   initial begin : monitor
      rd_t  r;
      exp_t e;
      time  t;
      int   ov_cnt;
      int   cmp_cnt;
      ov_cnt  = 0;
      cmp_cnt = 0;
      forever begin
         @(negedge CLK);
         t = $time;
         if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            RD_Addr = r.addr;
            #1;
            check($sformatf("R%0d", r.addr), RD_Data, r.val);
            if (r.chk_cmp) check("CMP_Flag", CMP_Flag, r.cmpf);
         end
         if (CPU_Reset) begin
            ov_cnt  = 0;
            cmp_cnt = 0;
         end else begin
            if (OV_EN)            ov_cnt++;
            if (COMPARATORREG_EN) cmp_cnt++;
            if (DONE) begin
               if (exp_q.size() == 0) begin
                  check("spurious DONE", DONE, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("DONE latency", t - e.hs, 15);
                  check("ALU_OPCode", ALU_OPCode, e.v.op);
                  check("ALU_A", ALU_A, e.v.a);
                  check("ALU_B", ALU_B, e.v.b);
                  check("OV_EN pulses", ov_cnt, e.v.ov_en);
                  check("CMPREG_EN pulses", cmp_cnt, e.v.cmp_en);
                  if (e.v.chk_ov) check("ALU_OV", ALU_OV, e.v.ov);
                  rd_q.push_back(mkrd(e.v.dst, e.v.res, e.v.cmp_en, e.v.cmpf));
               end
               ov_cnt  = 0;
               cmp_cnt = 0;
            end
         end
      end
   end

   task automatic send(input vec_t v, input bit track, output time hs);
      int   n;
      exp_t e;
      n = 0;
      bus.IN_Valid  = 1'b1;
      bus.IN_OPCode = v.op;
      bus.IN_Dst    = v.dst;
      bus.IN_SrcA   = v.sa;
      bus.IN_SrcB   = v.sb;
      bus.IN_UseImm = v.ui;
      bus.IN_Imm    = v.imm;
      while (!bus.IN_Ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.IN_Ready) check("handshake timeout", bus.IN_Ready, 1);
      @(posedge CLK);
      hs = $time;
      if (track) begin
         e.v  = v;
         e.hs = hs;
         exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("drain", exp_q.size() + rd_q.size(), 0);
      @(negedge CLK);
      #2;
   endtask

   initial begin : stimulus
      vec_t tbl[10];
      vec_t abort_v;
      time  hs0, hs1;

      //            op    dst sa  sb  ui imm    a      b      res    ove cme cko ov cmpf
      tbl[0] = mk(4'h0, 1, 0, 0, 1, 8'h05, 8'h00, 8'h05, 8'h05, 1, 0, 1, 0, 0);
      tbl[1] = mk(4'h0, 2, 1, 0, 1, 8'hFB, 8'h05, 8'hFB, 8'h00, 1, 0, 1, 1, 0);
      tbl[2] = mk(4'hC, 4, 1, 0, 1, 8'h05, 8'h05, 8'h05, 8'h00, 0, 1, 0, 0, 1);
      tbl[3] = mk(4'hD, 4, 1, 0, 1, 8'h03, 8'h05, 8'h03, 8'h00, 0, 1, 0, 0, 0);
      tbl[4] = mk(4'hD, 4, 2, 1, 0, 8'h00, 8'h00, 8'h05, 8'h00, 0, 1, 0, 0, 1);
      tbl[5] = mk(4'h1, 5, 1, 0, 1, 8'h07, 8'h05, 8'h07, 8'hFE, 1, 0, 1, 1, 0);
      tbl[6] = mk(4'h4, 6, 5, 1, 0, 8'h00, 8'hFE, 8'h05, 8'hFB, 0, 0, 0, 0, 0);
      tbl[7] = mk(4'h0, 7, 1, 0, 1, 8'h10, 8'h05, 8'h10, 8'h15, 1, 0, 1, 0, 0);
      tbl[8] = mk(4'h0, 0, 7, 0, 1, 8'h01, 8'h15, 8'h01, 8'h16, 1, 0, 1, 0, 0);
      tbl[9] = mk(4'h0, 3, 3, 0, 1, 8'h09, 8'h00, 8'h09, 8'h09, 1, 0, 1, 0, 0);
      abort_v = mk(4'h0, 3, 7, 0, 1, 8'h01, 8'h15, 8'h01, 8'h16, 1, 0, 0, 0, 0);

      bus.IN_Valid  = 1'b0;
      bus.IN_OPCode = '0;
      bus.IN_Dst    = '0;
      bus.IN_SrcA   = '0;
      bus.IN_SrcB   = '0;
      bus.IN_UseImm = 1'b0;
      bus.IN_Imm    = '0;

      CPU_Reset = 1'b1;
      repeat (2) @(negedge CLK);
      #2 CPU_Reset = 1'b0;
      @(negedge CLK);
      check("reset IN_Ready", bus.IN_Ready, 1);
      check("reset DONE", DONE, 0);
      check("reset OV_EN", OV_EN, 0);
      check("reset CMPREG_EN", COMPARATORREG_EN, 0);
      check("reset ALU_OPCode", ALU_OPCode, 0);
      check("reset ALU_A", ALU_A, 0);
      check("reset ALU_B", ALU_B, 0);
      check("reset CMP_Flag", CMP_Flag, 0);
      for (int a = 0; a < 8; a++) rd_q.push_back(mkrd(3'(a), 8'h00, 1'b0, 1'b0));
      drain();

      for (int k = 0; k < 7; k++) begin
         send(tbl[k], 1'b1, hs0);
         bus.IN_Valid = 1'b0;
      end
      drain();

      // Valid held high across two dependent instructions.
      send(tbl[7], 1'b1, hs0);
      send(tbl[8], 1'b1, hs1);
      bus.IN_Valid = 1'b0;
      check("back-to-back spacing", hs1 - hs0, 30);
      drain();

      // Reset lands in EXEC of a write to R3: nothing may retire.
      send(abort_v, 1'b0, hs0);
      bus.IN_Valid = 1'b0;
      check("EXEC OV_EN", OV_EN, 1);
      check("EXEC IN_Ready", bus.IN_Ready, 0);
      #2 CPU_Reset = 1'b1;
      #1;
      check("abort IN_Ready", bus.IN_Ready, 1);
      check("abort DONE", DONE, 0);
      check("abort OV_EN", OV_EN, 0);
      check("abort ALU_A", ALU_A, 0);
      @(negedge CLK);
      @(negedge CLK);
      #2 CPU_Reset = 1'b0;
      rd_q.push_back(mkrd(3'd3, 8'h00, 1'b1, 1'b0));
      rd_q.push_back(mkrd(3'd7, 8'h00, 1'b0, 1'b0));
      rd_q.push_back(mkrd(3'd0, 8'h00, 1'b0, 1'b0));
      rd_q.push_back(mkrd(3'd1, 8'h00, 1'b0, 1'b0));
      drain();

      send(tbl[9], 1'b1, hs0);
      bus.IN_Valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
